// File: rtl/collision_ctrl.sv
// -----------------------------------------------------------------------------
// collision_ctrl
//
// Purpose
//   Game-state owner for the frog/car game. Each cycle it registers two terms
//   from the raw grid positions: "frog overlaps the car" and "frog is on the
//   goal row". A four-state FSM acts on those registered terms one cycle later
//   and keeps lives, score and level. It also runs the hit / level-up hold
//   periods and handles game over and restart.
//
// Handshake / timing contract
//   There is no valid/ready traffic here. Positions are level inputs and are
//   sampled every clock. i_Frame_Tick and i_Start are single-cycle qualifiers
//   sampled on the rising edge. o_Hit and o_Frog_Reset are registered
//   one-cycle pulses and are never high in the same cycle. Every other output
//   is a registered level. An input change reaches o_Hit or o_State after
//   exactly two clock edges: one edge for the term register, one for the FSM.
//
// Ports
//   i_Clk         system clock
//   i_Rst_L       synchronous reset, active low
//   i_Frame_Tick  one-cycle pulse per video frame (hold-period time base)
//   i_Start       restart request, honoured only in S_GAME_OVER
//   i_Frog_X/Y    frog grid position
//   i_Car_X/Y     car grid position (car occupies c_CAR_WIDTH cells from X)
//   o_Hit         pulse on entry to S_HIT (also on the fatal hit)
//   o_Frog_Reset  pulse telling the frog controller to return to start
//   o_Lives       remaining lives
//   o_Score       goals reached, saturating at 255
//   o_Level       current level, saturating at 15
//   o_Game_Over   high while in S_GAME_OVER
//   o_State       FSM state: 00 PLAY, 01 HIT, 10 LEVEL_UP, 11 GAME_OVER
// -----------------------------------------------------------------------------
module collision_ctrl #(
  parameter int c_MAX_X      = 20,
  parameter int c_CAR_WIDTH  = 2,
  parameter int c_GOAL_Y     = 0,
  parameter int c_NUM_LIVES  = 3,
  parameter int c_HIT_FRAMES = 30,
  parameter int c_WIN_FRAMES = 30
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Frame_Tick,
  input  logic       i_Start,
  input  logic [5:0] i_Frog_X,
  input  logic [5:0] i_Frog_Y,
  input  logic [5:0] i_Car_X,
  input  logic [5:0] i_Car_Y,
  output logic       o_Hit,
  output logic       o_Frog_Reset,
  output logic [2:0] o_Lives,
  output logic [7:0] o_Score,
  output logic [3:0] o_Level,
  output logic       o_Game_Over,
  output logic [1:0] o_State
);

  typedef enum logic [1:0] {
    S_PLAY      = 2'b00,
    S_HIT       = 2'b01,
    S_LEVEL_UP  = 2'b10,
    S_GAME_OVER = 2'b11
  } state_t;

  state_t     r_State;
  logic       r_Collide;
  logic       r_Goal;
  logic       r_Hit;
  logic       r_Frog_Reset;
  logic       r_Game_Over;
  logic [2:0] r_Lives;
  logic [7:0] r_Score;
  logic [3:0] r_Level;
  logic [7:0] r_Hold_Cnt;

  // Overlap arithmetic is done 7 bits wide. The wrapped distance
  // Frog_X + c_MAX_X - Car_X can then never overflow for legal 6-bit columns.
  logic [6:0] w_Frog_X7;
  logic [6:0] w_Car_X7;
  logic [6:0] w_Dx;
  logic       w_Overlap;
  logic       w_On_Goal;
  logic       w_Hit_Done;
  logic       w_Win_Done;

  assign w_Frog_X7 = {1'b0, i_Frog_X};
  assign w_Car_X7  = {1'b0, i_Car_X};

  // Distance from the car's left cell to the frog, measured rightward with
  // wrap-around at c_MAX_X. The frog is on the car when that distance is
  // less than the car length.
  assign w_Dx = (w_Frog_X7 >= w_Car_X7) ? (w_Frog_X7 - w_Car_X7)
                                        : (w_Frog_X7 + 7'(c_MAX_X) - w_Car_X7);

  // An off-grid column on either side disables the overlap. Without this, a
  // stray out-of-range value could alias through the wrap arithmetic.
  assign w_Overlap = (i_Frog_Y == i_Car_Y)
                  && (w_Frog_X7 < 7'(c_MAX_X))
                  && (w_Car_X7  < 7'(c_MAX_X))
                  && (w_Dx      < 7'(c_CAR_WIDTH));

  assign w_On_Goal = (i_Frog_Y == 6'(c_GOAL_Y));

  // A hold period ends on the tick that brings the count to its target.
  assign w_Hit_Done = i_Frame_Tick && (r_Hold_Cnt == 8'(c_HIT_FRAMES - 1));
  assign w_Win_Done = i_Frame_Tick && (r_Hold_Cnt == 8'(c_WIN_FRAMES - 1));

  // Term register. This stage is the only one that looks at the raw
  // positions, so no input has a combinational path to an output.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Collide <= 1'b0;
      r_Goal    <= 1'b0;
    end else begin
      r_Collide <= w_Overlap;
      r_Goal    <= w_On_Goal;
    end
  end

  // Game FSM. Both pulses default low every cycle, so each one lasts a single
  // cycle. They are raised on different transitions, so they never coincide.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_State      <= S_PLAY;
      r_Lives      <= 3'(c_NUM_LIVES);
      r_Score      <= 8'd0;
      r_Level      <= 4'd0;
      r_Hold_Cnt   <= 8'd0;
      r_Hit        <= 1'b0;
      r_Frog_Reset <= 1'b0;
      r_Game_Over  <= 1'b0;
    end else begin
      r_Hit        <= 1'b0;
      r_Frog_Reset <= 1'b0;

      case (r_State)
        S_PLAY: begin
          // Collision takes priority over reaching the goal row.
          if (r_Collide) begin
            r_Hit      <= 1'b1;
            r_Hold_Cnt <= 8'd0;
            if (r_Lives > 3'd1) begin
              r_Lives <= r_Lives - 3'd1;
              r_State <= S_HIT;
            end else begin
              r_Lives     <= 3'd0;
              r_State     <= S_GAME_OVER;
              r_Game_Over <= 1'b1;
            end
          end else if (r_Goal) begin
            if (r_Score != 8'hFF) r_Score <= r_Score + 8'd1;
            if (r_Level != 4'hF)  r_Level <= r_Level + 4'd1;
            r_Frog_Reset <= 1'b1;
            r_Hold_Cnt   <= 8'd0;
            r_State      <= S_LEVEL_UP;
          end
        end

        S_HIT: begin
          // Count frames only. Collisions seen here are deliberately dropped.
          // The frog goes back to its start cell when the penalty ends.
          if (w_Hit_Done) begin
            r_Hold_Cnt   <= 8'd0;
            r_Frog_Reset <= 1'b1;
            r_State      <= S_PLAY;
          end else if (i_Frame_Tick) begin
            r_Hold_Cnt <= r_Hold_Cnt + 8'd1;
          end
        end

        S_LEVEL_UP: begin
          // The frog was already sent home on entry, so exit emits no pulse.
          if (w_Win_Done) begin
            r_Hold_Cnt <= 8'd0;
            r_State    <= S_PLAY;
          end else if (i_Frame_Tick) begin
            r_Hold_Cnt <= r_Hold_Cnt + 8'd1;
          end
        end

        S_GAME_OVER: begin
          // Outputs freeze until a restart request arrives.
          if (i_Start) begin
            r_Lives      <= 3'(c_NUM_LIVES);
            r_Score      <= 8'd0;
            r_Level      <= 4'd0;
            r_Hold_Cnt   <= 8'd0;
            r_Frog_Reset <= 1'b1;
            r_Game_Over  <= 1'b0;
            r_State      <= S_PLAY;
          end
        end

        default: begin
          r_State <= S_PLAY;
        end
      endcase
    end
  end

  assign o_Hit        = r_Hit;
  assign o_Frog_Reset = r_Frog_Reset;
  assign o_Lives      = r_Lives;
  assign o_Score      = r_Score;
  assign o_Level      = r_Level;
  assign o_Game_Over  = r_Game_Over;
  assign o_State      = r_State;

endmodule

// File: tb/tb_collision_ctrl.sv
// -----------------------------------------------------------------------------
// tb_collision_ctrl
//   Directed bench for collision_ctrl using default parameters (grid 20 wide,
//   car 2 cells, goal row 0, 3 lives, 30-frame holds).
//   Inputs are driven and outputs sampled on the falling clock edge. A value
//   set at falling edge N therefore shows on o_Hit / o_State at falling edge
//   N+2.
// -----------------------------------------------------------------------------
module tb_collision_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_l;
  logic       tick;
  logic       start;
  logic [5:0] fx, fy, cx, cy;
  logic       o_hit, o_fr, o_go;
  logic [2:0] o_lives;
  logic [7:0] o_score;
  logic [3:0] o_level;
  logic [1:0] o_state;

  int  n_vec   = 0;
  int  n_miss  = 0;
  int  hit_cnt = 0;
  int  fr_cnt  = 0;
  int  snap_hit, snap_fr;
  bit  ok;

  collision_ctrl dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_l),
    .i_Frame_Tick (tick),
    .i_Start      (start),
    .i_Frog_X     (fx),
    .i_Frog_Y     (fy),
    .i_Car_X      (cx),
    .i_Car_Y      (cy),
    .o_Hit        (o_hit),
    .o_Frog_Reset (o_fr),
    .o_Lives      (o_lives),
    .o_Score      (o_score),
    .o_Level      (o_level),
    .o_Game_Over  (o_go),
    .o_State      (o_state)
  );

  // ---------------- pulse monitor ----------------
  // Counts pulses just after each rising edge. This keeps it off the falling
  // edge that the stimulus uses.
  always @(posedge clk) begin
    #1;
    if (o_hit) hit_cnt++;
    if (o_fr)  fr_cnt++;
    if (o_hit && o_fr) begin
      n_miss++;
      $display("FAIL pulse_overlap: o_Hit and o_Frog_Reset both high at %0t", $time);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    step();
    step();
    rst_l = 1'b1;
  endtask

  task automatic send_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic send_ticks(input int n);
    for (int i = 0; i < n; i++) send_tick();
  endtask

  task automatic set_pos(input int f_x, input int f_y, input int c_x, input int c_y);
    fx = 6'(f_x);
    fy = 6'(f_y);
    cx = 6'(c_x);
    cy = 6'(c_y);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input string nm, output bit got);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (o_state == s) begin
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: timeout waiting for state %0d, got %0d", nm, s, o_state);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0] fx, fy, cx, cy;
    logic       e_hit;
    logic       e_fr;
    logic [1:0] e_state;
    logic [2:0] e_lives;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // Two falling edges after the positions are applied from a fresh reset.
    vecs[0]  = '{6'd5,  6'd10, 6'd5,  6'd13, 1'b0, 1'b0, 2'b00, 3'd3}; // different rows
    vecs[1]  = '{6'd19, 6'd13, 6'd18, 6'd13, 1'b1, 1'b0, 2'b01, 3'd2}; // dx=1
    vecs[2]  = '{6'd0,  6'd13, 6'd19, 6'd13, 1'b1, 1'b0, 2'b01, 3'd2}; // wrap dx=1
    vecs[3]  = '{6'd1,  6'd13, 6'd19, 6'd13, 1'b0, 1'b0, 2'b00, 3'd3}; // wrap dx=2
    vecs[4]  = '{6'd5,  6'd7,  6'd5,  6'd7,  1'b1, 1'b0, 2'b01, 3'd2}; // dx=0
    vecs[5]  = '{6'd6,  6'd7,  6'd5,  6'd7,  1'b1, 1'b0, 2'b01, 3'd2}; // dx=1
    vecs[6]  = '{6'd7,  6'd7,  6'd5,  6'd7,  1'b0, 1'b0, 2'b00, 3'd3}; // dx=2
    vecs[7]  = '{6'd4,  6'd7,  6'd5,  6'd7,  1'b0, 1'b0, 2'b00, 3'd3}; // left of car, dx=19
    vecs[8]  = '{6'd20, 6'd7,  6'd19, 6'd7,  1'b0, 1'b0, 2'b00, 3'd3}; // frog off grid
    vecs[9]  = '{6'd0,  6'd7,  6'd20, 6'd7,  1'b0, 1'b0, 2'b00, 3'd3}; // car off grid
    vecs[10] = '{6'd3,  6'd0,  6'd10, 6'd5,  1'b0, 1'b1, 2'b10, 3'd3}; // goal, no car
    vecs[11] = '{6'd3,  6'd0,  6'd3,  6'd0,  1'b1, 1'b0, 2'b01, 3'd2}; // goal + car: hit wins
    vecs[12] = '{6'd0,  6'd0,  6'd19, 6'd0,  1'b1, 1'b0, 2'b01, 3'd2}; // goal row, wrapped car
  end

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    rst_l = 1'b0;
    tick  = 1'b0;
    start = 1'b0;
    set_pos(5, 10, 5, 13);
    do_reset();

    // Reset values
    chk("rst_state", o_state, 0);
    chk("rst_lives", o_lives, 3);
    chk("rst_score", o_score, 0);
    chk("rst_level", o_level, 0);
    chk("rst_go",    o_go,    0);
    chk("rst_hit",   o_hit,   0);
    chk("rst_fr",    o_fr,    0);

    // Test 1: no overlap for 100 cycles
    steps(100);
    chk("t1_hits",  hit_cnt, 0);
    chk("t1_lives", o_lives, 3);
    chk("t1_state", o_state, 0);

    // Table-driven overlap/goal vectors, each from a fresh reset
    for (int v = 0; v < 13; v++) begin
      do_reset();
      set_pos(vecs[v].fx, vecs[v].fy, vecs[v].cx, vecs[v].cy);
      step();
      chk($sformatf("v%0d_hit_early", v), o_hit, 0);
      step();
      chk($sformatf("v%0d_hit", v),   o_hit,   vecs[v].e_hit);
      chk($sformatf("v%0d_fr", v),    o_fr,    vecs[v].e_fr);
      chk($sformatf("v%0d_state", v), o_state, vecs[v].e_state);
      chk($sformatf("v%0d_lives", v), o_lives, vecs[v].e_lives);
    end

    // Test 2: hit, overlap ignored during HIT, re-hit right after exit
    do_reset();
    set_pos(19, 13, 18, 13);
    step();
    chk("t2_hit_n1", o_hit, 0);
    step();
    chk("t2_hit_n2", o_hit,   1);
    chk("t2_lives",  o_lives, 2);
    chk("t2_state",  o_state, 1);
    set_pos(0, 13, 19, 13);
    step();
    chk("t2_hit_n3", o_hit, 0);
    snap_hit = hit_cnt;
    snap_fr  = fr_cnt;
    send_ticks(29);
    chk("t2_hold_state", o_state, 1);
    chk("t2_hold_lives", o_lives, 2);
    chk("t2_hold_hits",  hit_cnt, snap_hit);
    chk("t2_hold_fr",    fr_cnt,  snap_fr);
    send_tick();
    chk("t2_exit_state", o_state, 0);
    chk("t2_exit_fr",    o_fr,    1);
    chk("t2_exit_hit",   o_hit,   0);
    step();
    chk("t2_rehit",       o_hit,   1);
    chk("t2_rehit_lives", o_lives, 1);
    chk("t2_rehit_state", o_state, 1);
    chk("t2_rehit_fr",    o_fr,    0);

    // Test 3: last life lost, game over, restart
    send_ticks(30);
    chk("t3_exit_fr", o_fr, 1);
    step();
    chk("t3_go_state", o_state, 3);
    chk("t3_go_lives", o_lives, 0);
    chk("t3_go_flag",  o_go,    1);
    chk("t3_go_hit",   o_hit,   1);
    set_pos(5, 10, 19, 13);
    send_ticks(5);
    chk("t3_go_hold", o_state, 3);
    chk("t3_go_hit2", o_hit,   0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_rs_state", o_state, 0);
    chk("t3_rs_lives", o_lives, 3);
    chk("t3_rs_score", o_score, 0);
    chk("t3_rs_fr",    o_fr,    1);
    chk("t3_rs_go",    o_go,    0);
    // i_Start in PLAY must do nothing
    snap_fr = fr_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t3_start_play_fr",    fr_cnt,  snap_fr);
    chk("t3_start_play_state", o_state, 0);

    // Test 4: goal with a car on the goal row, then a clean goal
    do_reset();
    set_pos(3, 0, 3, 0);
    steps(2);
    chk("t4_carhit_state", o_state, 1);
    chk("t4_carhit_score", o_score, 0);
    do_reset();
    set_pos(3, 0, 10, 5);
    tick = 1'b1;                 // a tick on the entry edge must not count
    steps(2);
    tick = 1'b0;
    chk("t4_goal_state", o_state, 2);
    chk("t4_goal_score", o_score, 1);
    chk("t4_goal_level", o_level, 1);
    chk("t4_goal_fr",    o_fr,    1);
    set_pos(3, 10, 10, 5);
    snap_fr = fr_cnt;
    send_ticks(29);
    chk("t4_lu_hold", o_state, 2);
    send_tick();
    chk("t4_lu_exit",    o_state, 0);
    chk("t4_lu_exit_fr", fr_cnt,  snap_fr);

    // Test 5: repeated goals, level and score saturation
    do_reset();
    set_pos(3, 0, 10, 5);
    tick = 1'b1;
    for (int g = 1; g <= 256; g++) begin
      wait_state(2'b10, "t5_enter", ok);
      if (!ok) break;
      chk($sformatf("t5_score_%0d", g), o_score, (g > 255) ? 255 : g);
      chk($sformatf("t5_level_%0d", g), o_level, (g > 15) ? 15 : g);
      wait_state(2'b00, "t5_exit", ok);
      if (!ok) break;
    end
    // Lose all lives, then restart clears score and level
    set_pos(3, 0, 3, 0);
    wait_state(2'b11, "t5_go", ok);
    chk("t5_go_score", o_score, 255);
    chk("t5_go_level", o_level, 15);
    chk("t5_go_lives", o_lives, 0);
    tick = 1'b0;
    set_pos(3, 10, 3, 0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_rs_score", o_score, 0);
    chk("t5_rs_level", o_level, 0);
    chk("t5_rs_lives", o_lives, 3);

    // Test 6: reset in the middle of HIT
    do_reset();
    set_pos(5, 7, 5, 7);
    steps(2);
    chk("t6_hit_state", o_state, 1);
    send_ticks(10);
    snap_hit = hit_cnt;
    snap_fr  = fr_cnt;
    rst_l = 1'b0;
    step();
    chk("t6_rst_state", o_state, 0);
    chk("t6_rst_lives", o_lives, 3);
    rst_l = 1'b1;
    set_pos(5, 10, 5, 7);
    steps(3);
    chk("t6_no_hit", hit_cnt, snap_hit);
    chk("t6_no_fr",  fr_cnt,  snap_fr);
    // Counter must restart from zero: a fresh HIT needs the full 30 ticks
    set_pos(5, 7, 5, 7);
    steps(2);
    chk("t6_rehit_state", o_state, 1);
    set_pos(5, 10, 5, 7);
    send_ticks(29);
    chk("t6_hold29", o_state, 1);
    send_tick();
    chk("t6_exit30",    o_state, 0);
    chk("t6_exit30_fr", o_fr,    1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
